lockstep_pair_ctrl: RTL and testbench
=====================================

// Module: lockstep_pair_ctrl
// PURPOSE
// - Harness controller for a two-core relational (product) verification setup: two identical
//   cores run two programs; this block keeps them in retirement lockstep, gates fetch, flags
//   completion and tracks whether an attacker can tell the two runs apart by timing.
// - Combines three functions: clock-enable lockstep sync, fetch/finish control, and attacker
//   timing observer. Sits beside the two cores; its outputs drive their clock enables and
//   fetch enables.
// PARAMETERS
// - PROG_END_ADDR   32'h0000_0100  first fetch address beyond the program; fetch there stops a core
// - DRAIN_CYCLES    8              idle cycles after both fetches stop before finished_o asserts
// - STALL_TIMEOUT   64             max cycles a core is held waiting for its partner; 1..255
// PORTS
// - clk_i            in   1   harness clock
// - rst_i            in   1   synchronous active-high reset
// - retire_1_i       in   1   core 1 retirement valid; held while core 1 is clock-gated
// - retire_2_i       in   1   core 2 retirement valid; held while core 2 is clock-gated
// - fetch_1_i        in   1   core 1 issuing an instruction fetch this cycle
// - fetch_2_i        in   1   core 2 issuing an instruction fetch this cycle
// - instr_addr_1_i   in   32  core 1 fetch address
// - instr_addr_2_i   in   32  core 2 fetch address
// - clk_en_1_o       out  1   core 1 clock enable (1 = core 1 advances this cycle)
// - clk_en_2_o       out  1   core 2 clock enable
// - retire_o         out  1   paired retirement: both cores retire together this cycle
// - enable_1_o       out  1   core 1 fetch enable
// - enable_2_o       out  1   core 2 fetch enable
// - finished_o       out  1   both runs complete and drained (sticky)
// - atk_equiv_o      out  1   clock-enable traces of both cores identical since reset (sticky)
// BEHAVIOUR
// - Reset (rst_i=1 at a clk_i edge): wait counter=0, drain counter=0, enable_1_o=enable_2_o=1,
//   finished_o=0, atk_equiv_o=1. While rst_i=1: clk_en_1_o=clk_en_2_o=1, retire_o=0.
//   Reset mid-operation restores every one of these values on the next edge.
// - Lockstep, combinational outputs:
//   retire_o   = retire_1_i & retire_2_i & ~rst_i
//   clk_en_1_o = ~(retire_1_i & ~retire_2_i) | timeout
//   clk_en_2_o = ~(retire_2_i & ~retire_1_i) | timeout
//   A core that retires alone is frozen with its retire held until the partner retires.
//   Both then advance and retire_o pulses for exactly that cycle.
// - Timeout: an 8-bit wait counter increments each cycle exactly one retire_k_i is high and
//   clears otherwise. timeout = (counter == STALL_TIMEOUT). It releases the frozen core for
//   one cycle, and retire_o stays 0 in that cycle. The counter saturates and never wraps.
// - Fetch control: on an edge with fetch_k_i=1 and instr_addr_k_i >= PROG_END_ADDR (unsigned),
//   enable_k_o clears and stays 0 until reset. The two cores are independent; simultaneous
//   events on both clear both.
// - Finish: once enable_1_o=enable_2_o=0, the drain counter counts cycles with
//   retire_1_i=retire_2_i=0 and clears on any retire. When it reaches DRAIN_CYCLES,
//   finished_o is set next edge and stays set.
// - Attacker: each edge, if clk_en_1_o != clk_en_2_o then atk_equiv_o clears (sticky 0).
//   It is registered, one cycle of latency. Updates stop once finished_o=1.
// TESTING
// - Both retires high same cycle, repeated 10x -> retire_o=1 each cycle, clk_en both 1,
//   atk_equiv_o stays 1.
// - retire_1_i=1 for 3 cycles, then retire_2_i=1 -> clk_en_1_o=0 for 3 cycles,
//   retire_o=1 on 4th, atk_equiv_o=0 from next cycle.
// - retire_1_i held, retire_2_i=0 for 70 cycles (STALL_TIMEOUT=64) -> clk_en_1_o=1 exactly at
//   wait count 64, retire_o never 1.
// - fetch_1_i=1 at addr 0x100 -> enable_1_o=0 next cycle, enable_2_o still 1. Fetch at 0xFC
//   -> no change.
// - Both enables cleared, then 8 idle cycles -> finished_o=1 on the 9th edge. A retire at idle
//   cycle 5 restarts the count.
// - Assert rst_i mid-run with atk_equiv_o=0, finished_o=1 -> next edge all outputs at reset
//   values.

Source files
------------

// File: rtl/lockstep_pair_ctrl.sv
// Lockstep harness controller for a pair of identical cores running two programs.
// It holds the cores in retirement lockstep through their clock enables, stops fetch
// when a core runs past the program, flags completion once both are drained, and
// watches whether the two clock-enable traces ever diverge. A diverging trace is what
// would let an observer tell the two runs apart by timing.
module lockstep_pair_ctrl #(
    parameter logic [31:0] PROG_END_ADDR = 32'h0000_0100,
    parameter int unsigned DRAIN_CYCLES  = 8,
    parameter int unsigned STALL_TIMEOUT = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        retire_1_i,
    input  logic        retire_2_i,
    input  logic        fetch_1_i,
    input  logic        fetch_2_i,
    input  logic [31:0] instr_addr_1_i,
    input  logic [31:0] instr_addr_2_i,
    output logic        clk_en_1_o,
    output logic        clk_en_2_o,
    output logic        retire_o,
    output logic        enable_1_o,
    output logic        enable_2_o,
    output logic        finished_o,
    output logic        atk_equiv_o
);

    localparam logic [7:0] TIMEOUT_VAL = 8'(STALL_TIMEOUT);
    localparam logic [7:0] DRAIN_VAL   = 8'(DRAIN_CYCLES);

    logic [7:0] wait_cnt;
    logic [7:0] drain_cnt;
    logic       solo;
    logic       timeout;
    logic       any_retire;
    logic       both_stopped;

    assign solo         = retire_1_i ^ retire_2_i;
    assign any_retire   = retire_1_i | retire_2_i;
    assign timeout      = (wait_cnt == TIMEOUT_VAL);
    assign both_stopped = ~enable_1_o & ~enable_2_o;

    // A core that retires alone is frozen until its partner catches up. The timeout
    // lets it slip one cycle so that a partner which never retires cannot deadlock it.
    // Both cores run freely while reset is held.
    assign retire_o   = retire_1_i & retire_2_i & ~rst_i;
    assign clk_en_1_o = rst_i | ~(retire_1_i & ~retire_2_i) | timeout;
    assign clk_en_2_o = rst_i | ~(retire_2_i & ~retire_1_i) | timeout;

    // Count consecutive cycles with exactly one core waiting. Saturate rather than wrap,
    // so that the timeout fires only once per stall.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_cnt <= 8'd0;
        end else if (solo) begin
            if (wait_cnt != 8'hFF) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end else begin
            wait_cnt <= 8'd0;
        end
    end

    // A fetch at or beyond the program end stops that core for good. The comparison is unsigned.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            enable_1_o <= 1'b1;
            enable_2_o <= 1'b1;
        end else begin
            if (fetch_1_i && (instr_addr_1_i >= PROG_END_ADDR)) begin
                enable_1_o <= 1'b0;
            end
            if (fetch_2_i && (instr_addr_2_i >= PROG_END_ADDR)) begin
                enable_2_o <= 1'b0;
            end
        end
    end

    // After both fetches stop, count idle cycles. Any retire means the pipeline is still
    // draining and restarts the count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drain_cnt  <= 8'd0;
            finished_o <= 1'b0;
        end else begin
            if (both_stopped) begin
                if (any_retire) begin
                    drain_cnt <= 8'd0;
                end else if (drain_cnt != DRAIN_VAL) begin
                    drain_cnt <= drain_cnt + 8'd1;
                end
            end
            if (both_stopped && (drain_cnt == DRAIN_VAL)) begin
                finished_o <= 1'b1;
            end
        end
    end

    // Sticky flag that records any divergence of the clock-enable traces. The flag is
    // frozen after completion, so the harness teardown does not disturb the verdict.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            atk_equiv_o <= 1'b1;
        end else if (!finished_o && (clk_en_1_o != clk_en_2_o)) begin
            atk_equiv_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lockstep_pair_ctrl.sv
// Directed bench for lockstep_pair_ctrl. The expected values are hand-derived.
module tb_lockstep_pair_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        retire_1, retire_2, fetch_1, fetch_2;
    logic [31:0] addr_1, addr_2;
    logic        clk_en_1, clk_en_2, retire, enable_1, enable_2, finished, atk_equiv;

    int checks = 0;
    int errors = 0;

    lockstep_pair_ctrl dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .retire_1_i     (retire_1),
        .retire_2_i     (retire_2),
        .fetch_1_i      (fetch_1),
        .fetch_2_i      (fetch_2),
        .instr_addr_1_i (addr_1),
        .instr_addr_2_i (addr_2),
        .clk_en_1_o     (clk_en_1),
        .clk_en_2_o     (clk_en_2),
        .retire_o       (retire),
        .enable_1_o     (enable_1),
        .enable_2_o     (enable_2),
        .finished_o     (finished),
        .atk_equiv_o    (atk_equiv)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    // Advance past the next rising edge and settle 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; retire_1 = 1'b1; retire_2 = 1'b1;
        fetch_1 = 1'b0; fetch_2 = 1'b0; addr_1 = 32'h0; addr_2 = 32'h0;
        #1;
        chk("rst_retire_gated", retire, 1'b0);
        chk("rst_clk_en_1", clk_en_1, 1'b1);
        chk("rst_clk_en_2", clk_en_2, 1'b1);
        tick();
        chk("rst_enable_1", enable_1, 1'b1);
        chk("rst_enable_2", enable_2, 1'b1);
        chk("rst_finished", finished, 1'b0);
        chk("rst_atk_equiv", atk_equiv, 1'b1);
        rst = 1'b0; retire_1 = 1'b0; retire_2 = 1'b0;
        tick();

        // Paired retirement, ten cycles in a row.
        for (int i = 0; i < 10; i++) begin
            retire_1 = 1'b1; retire_2 = 1'b1;
            #1;
            chk("pair_retire", retire, 1'b1);
            chk("pair_clk_en_1", clk_en_1, 1'b1);
            chk("pair_clk_en_2", clk_en_2, 1'b1);
            tick();
        end
        retire_1 = 1'b0; retire_2 = 1'b0;
        tick();
        chk("pair_atk_equiv", atk_equiv, 1'b1);

        // Core 1 retires alone for 3 cycles, then the partner catches up.
        for (int i = 0; i < 3; i++) begin
            retire_1 = 1'b1; retire_2 = 1'b0;
            #1;
            chk("skew_clk_en_1", clk_en_1, 1'b0);
            chk("skew_clk_en_2", clk_en_2, 1'b1);
            chk("skew_retire", retire, 1'b0);
            tick();
            chk("skew_atk_cleared", atk_equiv, 1'b0);
        end
        retire_2 = 1'b1;
        #1;
        chk("skew_join_retire", retire, 1'b1);
        chk("skew_join_clk_en_1", clk_en_1, 1'b1);
        chk("skew_join_clk_en_2", clk_en_2, 1'b1);
        tick();
        retire_1 = 1'b0; retire_2 = 1'b0;
        tick();

        // Core 1 stalls 70 cycles. The release happens only when the wait count is 64.
        retire_1 = 1'b1;
        for (int i = 0; i < 70; i++) begin
            #1;
            chk("stall_clk_en_1", clk_en_1, (i == 64));
            chk("stall_clk_en_2", clk_en_2, 1'b1);
            chk("stall_retire", retire, 1'b0);
            tick();
        end
        retire_1 = 1'b0;
        tick();

        // Fetch control.
        fetch_1 = 1'b1; addr_1 = 32'h0000_00FC;
        tick();
        chk("fetch_fc_enable_1", enable_1, 1'b1);
        addr_1 = 32'h0000_0100;
        tick();
        chk("fetch_end_enable_1", enable_1, 1'b0);
        chk("fetch_end_enable_2", enable_2, 1'b1);
        fetch_1 = 1'b0; addr_1 = 32'h0;
        fetch_2 = 1'b1; addr_2 = 32'hFFFF_FFFF;
        tick();
        chk("fetch_max_enable_2", enable_2, 1'b0);
        chk("fetch_max_enable_1", enable_1, 1'b0);
        fetch_2 = 1'b0; addr_2 = 32'h0;

        // Drain: 4 idle edges, a retire at idle cycle 5 restarts the count, 8 idle edges, finish on the 9th.
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("drain_early_finished", finished, 1'b0);
        end
        retire_1 = 1'b1;
        tick();
        chk("drain_retire_finished", finished, 1'b0);
        retire_1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("drain_count_finished", finished, 1'b0);
        end
        tick();
        chk("drain_done_finished", finished, 1'b1);
        tick();
        chk("finished_sticky", finished, 1'b1);
        chk("pre_rst_atk_equiv", atk_equiv, 1'b0);

        // Reset in mid-run.
        rst = 1'b1; retire_1 = 1'b1;
        #1;
        chk("midrst_clk_en_1", clk_en_1, 1'b1);
        chk("midrst_retire", retire, 1'b0);
        tick();
        chk("midrst_enable_1", enable_1, 1'b1);
        chk("midrst_enable_2", enable_2, 1'b1);
        chk("midrst_finished", finished, 1'b0);
        chk("midrst_atk_equiv", atk_equiv, 1'b1);
        rst = 1'b0; retire_1 = 1'b0;
        tick();
        chk("post_rst_finished", finished, 1'b0);
        chk("post_rst_atk_equiv", atk_equiv, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
